sal_axi_cmd_arb: RTL and testbench

SAL_AXI_CMD_ARB -- requirements
Module: sal_axi_cmd_arb

---
 rtl/sal_axi_cmd_arb.sv | 179 +++++++++++++++++
 tb/tb_sal_axi_cmd_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sal_axi_cmd_arb.sv
// sal_axi_cmd_arb: merges the AXI AW and AR request channels into one command
// stream for the DRAM scheduler, through a single-entry output register.
//
// Ports
//   clk, rst_n            : single rising-edge clock, synchronous active-low reset
//   aw_*                  : write-address request (valid/ready + id/addr/len/size/burst)
//   ar_*                  : read-address request, same shape as aw_*
//   w_done_i              : one-cycle pulse per completed W burst
//   cmd_*                 : merged command (valid/ready, write flag + payload)
//   wpend_o               : writes granted whose W burst has not completed yet
//   starve_o              : consecutive read grants while a write has been waiting
//
// Reads win by default. A write wins when it is the only eligible request, or
// when reads have already been granted STARVE_MAX times in a row over it. No
// more than WPEND_MAX writes may be outstanding. aw_ready_o/ar_ready_o are
// combinational so a request is taken in the same cycle it is presented.
module sal_axi_cmd_arb #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_LEN   = 4,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned WPEND_MAX  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic                             aw_valid_i,
    output logic                             aw_ready_o,
    input  logic [ID_WIDTH-1:0]              aw_id_i,
    input  logic [ADDR_WIDTH-1:0]            aw_addr_i,
    input  logic [ADDR_LEN-1:0]              aw_len_i,
    input  logic [2:0]                       aw_size_i,
    input  logic [1:0]                       aw_burst_i,

    input  logic                             ar_valid_i,
    output logic                             ar_ready_o,
    input  logic [ID_WIDTH-1:0]              ar_id_i,
    input  logic [ADDR_WIDTH-1:0]            ar_addr_i,
    input  logic [ADDR_LEN-1:0]              ar_len_i,
    input  logic [2:0]                       ar_size_i,
    input  logic [1:0]                       ar_burst_i,

    input  logic                             w_done_i,

    output logic                             cmd_valid_o,
    input  logic                             cmd_ready_i,
    output logic                             cmd_write_o,
    output logic [ID_WIDTH-1:0]              cmd_id_o,
    output logic [ADDR_WIDTH-1:0]            cmd_addr_o,
    output logic [ADDR_LEN-1:0]              cmd_len_o,
    output logic [2:0]                       cmd_size_o,
    output logic [1:0]                       cmd_burst_o,

    output logic [$clog2(WPEND_MAX+1)-1:0]   wpend_o,
    output logic [$clog2(STARVE_MAX+1)-1:0]  starve_o
);

    localparam int unsigned WPEND_W  = $clog2(WPEND_MAX + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic                  write;
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [ADDR_LEN-1:0]   len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } cmd_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e               r_state;
    cmd_t                 r_cmd;
    logic [WPEND_W-1:0]   r_wpend;
    logic [STARVE_W-1:0]  r_starve;

    logic                 w_can_accept;
    logic                 w_wpend_full;
    logic                 w_starved;
    logic                 w_wr_elig;
    logic                 w_grant_wr;
    logic                 w_grant_rd;
    logic                 w_accept;
    cmd_t                 w_next_cmd;

    // Register takes a new command when empty or when it drains this cycle.
    assign w_can_accept = (r_state == ST_EMPTY) || cmd_ready_i;

    // A completing W burst in the same cycle frees the slot a new AW needs.
    assign w_wpend_full = (r_wpend == WPEND_W'(WPEND_MAX));
    assign w_wr_elig    = aw_valid_i && (!w_wpend_full || w_done_i);
    assign w_starved    = (r_starve == STARVE_W'(STARVE_MAX));

    // Grants are masked by rst_n so neither ready is raised during reset.
    assign w_grant_wr = rst_n && w_can_accept && w_wr_elig && (!ar_valid_i || w_starved);
    assign w_grant_rd = rst_n && w_can_accept && ar_valid_i && !w_grant_wr;
    assign w_accept   = w_grant_wr || w_grant_rd;

    assign aw_ready_o = w_grant_wr;
    assign ar_ready_o = w_grant_rd;

    // Payload of the winning channel.
    always_comb begin
        w_next_cmd = '0;
        if (w_grant_wr) begin
            w_next_cmd.write = 1'b1;
            w_next_cmd.id    = aw_id_i;
            w_next_cmd.addr  = aw_addr_i;
            w_next_cmd.len   = aw_len_i;
            w_next_cmd.size  = aw_size_i;
            w_next_cmd.burst = aw_burst_i;
        end else begin
            w_next_cmd.write = 1'b0;
            w_next_cmd.id    = ar_id_i;
            w_next_cmd.addr  = ar_addr_i;
            w_next_cmd.len   = ar_len_i;
            w_next_cmd.size  = ar_size_i;
            w_next_cmd.burst = ar_burst_i;
        end
    end

    // Output register FSM plus outstanding-write and starvation counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_EMPTY;
            r_cmd    <= '0;
            r_wpend  <= '0;
            r_starve <= '0;
        end else begin
            if (r_state == ST_EMPTY) begin
                if (w_accept) begin
                    r_state <= ST_FULL;
                end
            end else begin
                if (cmd_ready_i && !w_accept) begin
                    r_state <= ST_EMPTY;
                end
            end

            // Payload only moves on accept, so a stalled command holds.
            if (w_accept) begin
                r_cmd <= w_next_cmd;
            end

            // Grant and completion in the same cycle cancel; a completion
            // with nothing outstanding is ignored rather than wrapping.
            if (w_grant_wr && !w_done_i) begin
                r_wpend <= r_wpend + WPEND_W'(1);
            end else if (!w_grant_wr && w_done_i && (r_wpend != '0)) begin
                r_wpend <= r_wpend - WPEND_W'(1);
            end

            if (w_grant_wr || !aw_valid_i) begin
                r_starve <= '0;
            end else if (w_grant_rd && !w_starved) begin
                r_starve <= r_starve + STARVE_W'(1);
            end
        end
    end

    assign cmd_valid_o = (r_state == ST_FULL);
    assign cmd_write_o = r_cmd.write;
    assign cmd_id_o    = r_cmd.id;
    assign cmd_addr_o  = r_cmd.addr;
    assign cmd_len_o   = r_cmd.len;
    assign cmd_size_o  = r_cmd.size;
    assign cmd_burst_o = r_cmd.burst;
    assign wpend_o     = r_wpend;
    assign starve_o    = r_starve;

    // Protocol check: a W completion must have a granted write behind it.
    a_no_spurious_wdone : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_done_i && (r_wpend == '0) && !w_grant_wr))
        else $warning("sal_axi_cmd_arb: w_done_i with no outstanding write burst");

endmodule

// File: tb/tb_sal_axi_cmd_arb.sv
// Bench for sal_axi_cmd_arb: per-feature tasks with inline checks; accepted
// requests are queued as expected commands and compared when they drain.
module tb_sal_axi_cmd_arb;

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 4;
    localparam int unsigned LW = 4;

    typedef struct packed {
        logic          wr;
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [2:0]    size;
        logic [1:0]    burst;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          aw_valid_i, aw_ready_o;
    logic [IW-1:0] aw_id_i;
    logic [AW-1:0] aw_addr_i;
    logic [LW-1:0] aw_len_i;
    logic [2:0]    aw_size_i;
    logic [1:0]    aw_burst_i;
    logic          ar_valid_i, ar_ready_o;
    logic [IW-1:0] ar_id_i;
    logic [AW-1:0] ar_addr_i;
    logic [LW-1:0] ar_len_i;
    logic [2:0]    ar_size_i;
    logic [1:0]    ar_burst_i;
    logic          w_done_i;
    logic          cmd_valid_o, cmd_ready_i, cmd_write_o;
    logic [IW-1:0] cmd_id_o;
    logic [AW-1:0] cmd_addr_o;
    logic [LW-1:0] cmd_len_o;
    logic [2:0]    cmd_size_o;
    logic [1:0]    cmd_burst_o;
    logic [2:0]    wpend_o;
    logic [3:0]    starve_o;

    int   checks = 0;
    int   errors = 0;
    cmd_t sb[$];

    always #5 clk = ~clk;

    sal_axi_cmd_arb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .aw_valid_i  (aw_valid_i),
        .aw_ready_o  (aw_ready_o),
        .aw_id_i     (aw_id_i),
        .aw_addr_i   (aw_addr_i),
        .aw_len_i    (aw_len_i),
        .aw_size_i   (aw_size_i),
        .aw_burst_i  (aw_burst_i),
        .ar_valid_i  (ar_valid_i),
        .ar_ready_o  (ar_ready_o),
        .ar_id_i     (ar_id_i),
        .ar_addr_i   (ar_addr_i),
        .ar_len_i    (ar_len_i),
        .ar_size_i   (ar_size_i),
        .ar_burst_i  (ar_burst_i),
        .w_done_i    (w_done_i),
        .cmd_valid_o (cmd_valid_o),
        .cmd_ready_i (cmd_ready_i),
        .cmd_write_o (cmd_write_o),
        .cmd_id_o    (cmd_id_o),
        .cmd_addr_o  (cmd_addr_o),
        .cmd_len_o   (cmd_len_o),
        .cmd_size_o  (cmd_size_o),
        .cmd_burst_o (cmd_burst_o),
        .wpend_o     (wpend_o),
        .starve_o    (starve_o)
    );

    // Writes are driven with size 3 / burst 1, reads with size 2 / burst 2.
    function automatic cmd_t mk(input logic wr, input logic [IW-1:0] id,
                                input logic [AW-1:0] addr, input logic [LW-1:0] len);
        cmd_t c;
        c.wr    = wr;
        c.id    = id;
        c.addr  = addr;
        c.len   = len;
        c.size  = wr ? 3'd3 : 3'd2;
        c.burst = wr ? 2'd1 : 2'd2;
        return c;
    endfunction

    task automatic drive_aw(input logic v, input logic [IW-1:0] id,
                            input logic [AW-1:0] addr, input logic [LW-1:0] len);
        aw_valid_i = v; aw_id_i = id; aw_addr_i = addr; aw_len_i = len;
        aw_size_i = 3'd3; aw_burst_i = 2'd1;
    endtask

    task automatic drive_ar(input logic v, input logic [IW-1:0] id,
                            input logic [AW-1:0] addr, input logic [LW-1:0] len);
        ar_valid_i = v; ar_id_i = id; ar_addr_i = addr; ar_len_i = len;
        ar_size_i = 3'd2; ar_burst_i = 2'd2;
    endtask

    // Called at the negedge: pops the scoreboard for a command draining at
    // the coming posedge, then advances to just after that posedge.
    task automatic finish_cycle();
        cmd_t got_c;
        cmd_t exp_c;
        if (cmd_valid_o && cmd_ready_i) begin
            got_c = {cmd_write_o, cmd_id_o, cmd_addr_o, cmd_len_o, cmd_size_o, cmd_burst_o};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got cmd %h, expected no command", got_c);
            end else begin
                exp_c = sb.pop_front();
                if (got_c !== exp_c) begin
                    errors++;
                    $display("FAIL sb_cmd: got %h expected %h", got_c, exp_c);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_ready_i = 1'b1; w_done_i = 1'b0;
        drive_aw(1'b1, 4'd1, 32'h55, 4'd1);
        drive_ar(1'b1, 4'd2, 32'h66, 4'd2);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (aw_ready_o !== 1'b0) begin errors++; $display("FAIL rst_aw_ready: got %b expected 0", aw_ready_o); end
        checks++; if (ar_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ar_ready: got %b expected 0", ar_ready_o); end
        checks++; if (cmd_valid_o !== 1'b0) begin errors++; $display("FAIL rst_cmd_valid: got %b expected 0", cmd_valid_o); end
        checks++; if ({cmd_write_o, cmd_id_o, cmd_addr_o, cmd_len_o, cmd_size_o, cmd_burst_o} !== 46'd0) begin
            errors++; $display("FAIL rst_cmd_payload: got %h expected 0",
                               {cmd_write_o, cmd_id_o, cmd_addr_o, cmd_len_o, cmd_size_o, cmd_burst_o});
        end
        checks++; if (wpend_o !== 3'd0) begin errors++; $display("FAIL rst_wpend: got %0d expected 0", wpend_o); end
        checks++; if (starve_o !== 4'd0) begin errors++; $display("FAIL rst_starve: got %0d expected 0", starve_o); end
        @(posedge clk);
        #1;
        drive_aw(1'b0, '0, '0, '0);
        drive_ar(1'b0, '0, '0, '0);
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_ar_single();
        cmd_ready_i = 1'b1;
        drive_ar(1'b1, 4'd3, 32'h1000, 4'd7);
        @(negedge clk);
        checks++; if (ar_ready_o !== 1'b1) begin errors++; $display("FAIL ar1_ar_ready: got %b expected 1", ar_ready_o); end
        checks++; if (aw_ready_o !== 1'b0) begin errors++; $display("FAIL ar1_aw_ready: got %b expected 0", aw_ready_o); end
        sb.push_back(mk(1'b0, 4'd3, 32'h1000, 4'd7));
        finish_cycle();
        drive_ar(1'b0, '0, '0, '0);
        @(negedge clk);
        checks++; if (cmd_valid_o !== 1'b1) begin errors++; $display("FAIL ar1_valid: got %b expected 1", cmd_valid_o); end
        checks++; if (cmd_write_o !== 1'b0) begin errors++; $display("FAIL ar1_write: got %b expected 0", cmd_write_o); end
        checks++; if (cmd_addr_o !== 32'h1000) begin errors++; $display("FAIL ar1_addr: got %h expected 1000", cmd_addr_o); end
        checks++; if (cmd_len_o !== 4'd7) begin errors++; $display("FAIL ar1_len: got %0d expected 7", cmd_len_o); end
        finish_cycle();
        @(negedge clk);
        checks++; if (cmd_valid_o !== 1'b0) begin errors++; $display("FAIL ar1_drained: got %b expected 0", cmd_valid_o); end
        finish_cycle();
    endtask

    task automatic test_backpressure();
        cmd_ready_i = 1'b0;
        drive_ar(1'b1, 4'd5, 32'h5000, 4'd2);
        @(negedge clk);
        checks++; if (ar_ready_o !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b expected 1", ar_ready_o); end
        sb.push_back(mk(1'b0, 4'd5, 32'h5000, 4'd2));
        finish_cycle();
        drive_ar(1'b1, 4'd6, 32'h5100, 4'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (ar_ready_o !== 1'b0) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0", i, ar_ready_o); end
            checks++;
            if (cmd_valid_o !== 1'b1 || cmd_id_o !== 4'd5 || cmd_addr_o !== 32'h5000 || cmd_len_o !== 4'd2) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d addr=%h len=%0d expected v=1 id=5 addr=5000 len=2",
                         i, cmd_valid_o, cmd_id_o, cmd_addr_o, cmd_len_o);
            end
            finish_cycle();
        end
        cmd_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (ar_ready_o !== 1'b1) begin errors++; $display("FAIL bp_b2b_ready: got %b expected 1", ar_ready_o); end
        sb.push_back(mk(1'b0, 4'd6, 32'h5100, 4'd4));
        finish_cycle();
        drive_ar(1'b0, '0, '0, '0);
        @(negedge clk);
        checks++; if (cmd_valid_o !== 1'b1 || cmd_addr_o !== 32'h5100) begin
            errors++; $display("FAIL bp_b2b_valid: got v=%b addr=%h expected v=1 addr=5100", cmd_valid_o, cmd_addr_o);
        end
        finish_cycle();
        @(negedge clk);
        checks++; if (cmd_valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", cmd_valid_o); end
        finish_cycle();
    endtask

    task automatic test_wpend_limit();
        cmd_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_aw(1'b1, 4'(i), 32'h2000 + 32'(i) * 32'h40, 4'd3);
            @(negedge clk);
            checks++; if (aw_ready_o !== 1'b1) begin errors++; $display("FAIL wp_grant[%0d]: got %b expected 1", i, aw_ready_o); end
            checks++; if (wpend_o !== 3'(i)) begin errors++; $display("FAIL wp_count[%0d]: got %0d expected %0d", i, wpend_o, i); end
            sb.push_back(mk(1'b1, 4'(i), 32'h2000 + 32'(i) * 32'h40, 4'd3));
            finish_cycle();
        end
        drive_aw(1'b1, 4'd4, 32'h2100, 4'd3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (aw_ready_o !== 1'b0) begin errors++; $display("FAIL wp_full_ready[%0d]: got %b expected 0", i, aw_ready_o); end
            checks++; if (wpend_o !== 3'd4) begin errors++; $display("FAIL wp_full_count[%0d]: got %0d expected 4", i, wpend_o); end
            finish_cycle();
        end
        w_done_i = 1'b1;
        @(negedge clk);
        checks++; if (aw_ready_o !== 1'b1) begin errors++; $display("FAIL wp_free_grant: got %b expected 1", aw_ready_o); end
        sb.push_back(mk(1'b1, 4'd4, 32'h2100, 4'd3));
        finish_cycle();
        w_done_i = 1'b0;
        drive_aw(1'b0, '0, '0, '0);
        @(negedge clk);
        checks++; if (wpend_o !== 3'd4) begin errors++; $display("FAIL wp_after_swap: got %0d expected 4", wpend_o); end
        finish_cycle();
        w_done_i = 1'b1;
        repeat (4) begin
            @(negedge clk);
            finish_cycle();
        end
        w_done_i = 1'b0;
        @(negedge clk);
        checks++; if (wpend_o !== 3'd0) begin errors++; $display("FAIL wp_retired: got %0d expected 0", wpend_o); end
        finish_cycle();
    endtask

    task automatic test_starvation();
        int   s = 0;
        int   wp = 0;
        logic done_next = 1'b0;
        cmd_ready_i = 1'b1;
        for (int k = 0; k < 27; k++) begin
            logic exp_wr;
            drive_aw(1'b1, 4'(k), 32'h3000 + 32'(k) * 32'd4, 4'd1);
            drive_ar(1'b1, 4'(k), 32'h4000 + 32'(k) * 32'd4, 4'd2);
            w_done_i = done_next;
            exp_wr = (s == 8);
            @(negedge clk);
            checks++; if (aw_ready_o !== exp_wr) begin errors++; $display("FAIL st_aw_ready[%0d]: got %b expected %b", k, aw_ready_o, exp_wr); end
            checks++; if (ar_ready_o !== !exp_wr) begin errors++; $display("FAIL st_ar_ready[%0d]: got %b expected %b", k, ar_ready_o, !exp_wr); end
            checks++; if (starve_o !== 4'(s)) begin errors++; $display("FAIL st_starve[%0d]: got %0d expected %0d", k, starve_o, s); end
            checks++; if (wpend_o !== 3'(wp)) begin errors++; $display("FAIL st_wpend[%0d]: got %0d expected %0d", k, wpend_o, wp); end
            if (exp_wr) sb.push_back(mk(1'b1, 4'(k), 32'h3000 + 32'(k) * 32'd4, 4'd1));
            else        sb.push_back(mk(1'b0, 4'(k), 32'h4000 + 32'(k) * 32'd4, 4'd2));
            finish_cycle();
            wp = wp + (exp_wr ? 1 : 0) - (done_next ? 1 : 0);
            if (exp_wr) s = 0;
            else if (s < 8) s = s + 1;
            done_next = exp_wr;
        end
        drive_aw(1'b0, '0, '0, '0);
        drive_ar(1'b0, '0, '0, '0);
        w_done_i = done_next;
        @(negedge clk);
        checks++; if (wpend_o !== 3'(wp)) begin errors++; $display("FAIL st_tail_wpend: got %0d expected %0d", wpend_o, wp); end
        finish_cycle();
        w_done_i = 1'b0;
        @(negedge clk);
        checks++; if (wpend_o !== 3'd0 || starve_o !== 4'd0) begin
            errors++; $display("FAIL st_idle: got wpend=%0d starve=%0d expected 0 0", wpend_o, starve_o);
        end
        finish_cycle();
    endtask

    task automatic test_spurious();
        w_done_i = 1'b1;
        @(negedge clk);
        checks++; if (wpend_o !== 3'd0) begin errors++; $display("FAIL sp_before: got %0d expected 0", wpend_o); end
        finish_cycle();
        w_done_i = 1'b0;
        @(negedge clk);
        checks++; if (wpend_o !== 3'd0) begin errors++; $display("FAIL sp_no_underflow: got %0d expected 0", wpend_o); end
        finish_cycle();
    endtask

    task automatic test_reset_midop();
        cmd_ready_i = 1'b1;
        drive_aw(1'b1, 4'd7, 32'h6000, 4'd0);
        @(negedge clk);
        checks++; if (aw_ready_o !== 1'b1) begin errors++; $display("FAIL mr_w1: got %b expected 1", aw_ready_o); end
        sb.push_back(mk(1'b1, 4'd7, 32'h6000, 4'd0));
        finish_cycle();
        drive_aw(1'b1, 4'd8, 32'h6040, 4'd0);
        @(negedge clk);
        checks++; if (aw_ready_o !== 1'b1) begin errors++; $display("FAIL mr_w2: got %b expected 1", aw_ready_o); end
        sb.push_back(mk(1'b1, 4'd8, 32'h6040, 4'd0));
        finish_cycle();
        drive_aw(1'b0, '0, '0, '0);
        cmd_ready_i = 1'b0;
        @(negedge clk);
        checks++; if (cmd_valid_o !== 1'b1 || wpend_o !== 3'd2) begin
            errors++; $display("FAIL mr_pre: got v=%b wpend=%0d expected v=1 wpend=2", cmd_valid_o, wpend_o);
        end
        finish_cycle();
        rst_n = 1'b0;
        drive_ar(1'b1, 4'd9, 32'h7000, 4'd1);
        @(negedge clk);
        checks++; if (ar_ready_o !== 1'b0 || aw_ready_o !== 1'b0) begin
            errors++; $display("FAIL mr_rst_ready: got ar=%b aw=%b expected 0 0", ar_ready_o, aw_ready_o);
        end
        finish_cycle();
        rst_n = 1'b1;
        cmd_ready_i = 1'b1;
        sb.delete();
        @(negedge clk);
        checks++; if (cmd_valid_o !== 1'b0 || wpend_o !== 3'd0 || starve_o !== 4'd0) begin
            errors++; $display("FAIL mr_post: got v=%b wpend=%0d starve=%0d expected 0 0 0", cmd_valid_o, wpend_o, starve_o);
        end
        checks++; if (ar_ready_o !== 1'b1) begin errors++; $display("FAIL mr_first_accept: got %b expected 1", ar_ready_o); end
        sb.push_back(mk(1'b0, 4'd9, 32'h7000, 4'd1));
        finish_cycle();
        drive_ar(1'b0, '0, '0, '0);
        @(negedge clk);
        checks++; if (cmd_valid_o !== 1'b1 || cmd_addr_o !== 32'h7000) begin
            errors++; $display("FAIL mr_cmd: got v=%b addr=%h expected v=1 addr=7000", cmd_valid_o, cmd_addr_o);
        end
        finish_cycle();
    endtask

    initial begin
        test_reset();
        test_ar_single();
        test_backpressure();
        test_wpend_limit();
        test_starvation();
        test_spurious();
        test_reset_midop();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d queued commands expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
